// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the EX-stage hazard controller.
// Forwarding select encodings, multi-cycle FSM states, PC register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline <-> EX hazard controller signal bundle.
// HAZARD_PERF_EN adds the StallCnt/FlushCnt performance counters.
interface ex_hazard_ctrl_if #(
  parameter int REG_AW = 4
`ifdef HAZARD_PERF_EN
  ,parameter int CNT_W = 16
`endif
);

  logic [REG_AW-1:0] Ra1D;
  logic [REG_AW-1:0] Ra2D;
  logic [REG_AW-1:0] Ra1E;
  logic [REG_AW-1:0] Ra2E;
  logic [REG_AW-1:0] WA3E;
  logic [REG_AW-1:0] WA3M;
  logic [REG_AW-1:0] WA3W;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemtoRegE;
  logic              PCSrcE;
  logic              MulStartE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              MulBusy;
  logic              MulDone;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  FlushCnt;
`endif

  modport master (
`ifdef HAZARD_PERF_EN
    input  StallCnt, FlushCnt,
`endif
    output Ra1D, Ra2D, Ra1E, Ra2E,
    output WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW,
    output MemtoRegE, PCSrcE, MulStartE,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM,
    input  MulBusy, MulDone
  );

  modport slave (
`ifdef HAZARD_PERF_EN
    output StallCnt, FlushCnt,
`endif
    input  Ra1D, Ra2D, Ra1E, Ra2E,
    input  WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW,
    input  MemtoRegE, PCSrcE, MulStartE,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE,
    output FlushD, FlushE, FlushM,
    output MulBusy, MulDone
  );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// Operand forwarding compare for one EX source register.
// M beats W; the PC register is never forwarded.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
)(
  input  logic [REG_AW-1:0] i_ra,
  input  logic [REG_AW-1:0] i_wa_m,
  input  logic [REG_AW-1:0] i_wa_w,
  input  logic              i_we_m,
  input  logic              i_we_w,
  output fwd_sel_t          o_sel
);

  logic w_not_pc;
  logic w_hit_m;
  logic w_hit_w;

  assign w_not_pc = (i_ra != REG_AW'(PC_REG));
  assign w_hit_m  = i_we_m && (i_wa_m == i_ra) && w_not_pc;
  assign w_hit_w  = i_we_w && (i_wa_w == i_ra) && w_not_pc;

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_m)
      o_sel = FWD_M;
    else if (w_hit_w)
      o_sel = FWD_W;
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding, load-use, branch flush, multi-cycle hold.
// Define HAZARD_PERF_EN for saturating stall/flush performance counters.
module ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int MUL_LAT = 4
`ifdef HAZARD_PERF_EN
  ,parameter int CNT_W  = 16
`endif
)(
  input logic             clk,
  input logic             rst,
  ex_hazard_ctrl_if.slave hz
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

  mul_state_t r_state;
  mul_state_t w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_hold;
  logic       w_done;
  logic       w_idle;
  logic       w_ld;
  logic       w_br;
  logic       w_lds;
  logic       w_stall_f;
  fwd_sel_t   w_fa;
  fwd_sel_t   w_fb;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .i_ra   (hz.Ra1E),
    .i_wa_m (hz.WA3M),
    .i_wa_w (hz.WA3W),
    .i_we_m (hz.RegWriteM),
    .i_we_w (hz.RegWriteW),
    .o_sel  (w_fa)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .i_ra   (hz.Ra2E),
    .i_wa_m (hz.WA3M),
    .i_wa_w (hz.WA3W),
    .i_we_m (hz.RegWriteM),
    .i_we_w (hz.RegWriteW),
    .o_sel  (w_fb)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // w_hold covers the issue cycle and every BUSY cycle before done
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (hz.MulStartE && !hz.PCSrcE) begin
          w_hold      = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          w_hold    = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  assign w_idle = (r_state == IDLE);
  assign w_ld   = hz.MemtoRegE &&
                  ((hz.WA3E == hz.Ra1D) || (hz.WA3E == hz.Ra2D));
  assign w_br   = w_idle && hz.PCSrcE;
  assign w_lds  = w_idle && !w_hold && !hz.PCSrcE && w_ld;

  assign w_stall_f    = rst && (w_hold || w_lds);
  assign hz.StallF    = w_stall_f;
  assign hz.StallD    = w_stall_f;
  assign hz.StallE    = rst && w_hold;
  assign hz.FlushD    = rst && w_br;
  assign hz.FlushE    = rst && (w_br || w_lds);
  assign hz.FlushM    = rst && w_hold;
  assign hz.MulBusy   = rst && !w_idle;
  assign hz.MulDone   = rst && w_done;
  assign hz.ForwardAE = rst ? w_fa : FWD_RF;
  assign hz.ForwardBE = rst ? w_fb : FWD_RF;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.StallCnt = r_stall_cnt;
  assign hz.FlushCnt = r_flush_cnt;
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Hazard and sequencing controller for the Execute stage of the 5-stage pipeline (F/D/E/M/W).
- Generates operand forwarding selects for the EX operand muxes.
- Detects load-use stalls and flushes the pipeline on a taken branch (PCSrcE).
- Runs a small FSM that holds EX for multi-cycle ALU operations (iterative multiply), stalling upstream stages and bubbling M.

Parameters:
REG_AW, 4, register address width (16 architectural registers, R15 = PC)
MUL_LAT, 4, total EX-occupancy cycles of a multi-cycle op, legal range 2..16
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-low
Ra1D  in  REG_AW  source reg 1 of the instruction in D
Ra2D  in  REG_AW  source reg 2 of the instruction in D
Ra1E  in  REG_AW  source reg 1 of the instruction in E
Ra2E  in  REG_AW  source reg 2 of the instruction in E
WA3E  in  REG_AW  destination reg in E
WA3M  in  REG_AW  destination reg in M
WA3W  in  REG_AW  destination reg in W
RegWriteM  in  1  M stage writes the register file
RegWriteW  in  1  W stage writes the register file
MemtoRegE  in  1  instruction in E is a load
PCSrcE  in  1  taken branch resolved in E (from the condition unit)
MulStartE  in  1  instruction in E is a multi-cycle op
ForwardAE  out  2  SrcA select: 00 = RD1E, 10 = ALUResultM, 01 = ResultW
ForwardBE  out  2  SrcB (pre-immediate mux) select, same encoding
StallF  out  1  hold the PC
StallD  out  1  hold the F/D register
StallE  out  1  hold the D/E register
FlushD  out  1  clear the F/D register
FlushE  out  1  clear the D/E register
FlushM  out  1  clear the E/M register (bubble)
MulBusy  out  1  FSM in BUSY
MulDone  out  1  one-cycle pulse; EX result valid this cycle

Behaviour:
- Reset: while rst==0 at a clk edge, FSM goes to IDLE and cnt to 0. While rst is sampled low, all outputs are 0 (combinational outputs gated by rst). Reset mid-op aborts immediately with no MulDone.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and WA3M==Ra1E and Ra1E!=15.
  - Otherwise 01 if RegWriteW and WA3W==Ra1E and Ra1E!=15.
  - Otherwise 00.
  - M has priority over W. ForwardBE uses the same rule with Ra2E.
- Load-use (combinational): ldStall = MemtoRegE and (WA3E==Ra1D or WA3E==Ra2D). On ldStall: StallF=StallD=1 and FlushE=1, for one cycle per occurrence.
- Branch: PCSrcE=1 → FlushD=1 and FlushE=1. PCSrcE overrides ldStall: StallF=StallD=0 in that cycle.
- FSM states are IDLE and BUSY; cnt is 4 bits.
  - IDLE with MulStartE=1 and PCSrcE=0 is the issue cycle: StallF=StallD=StallE=1, FlushM=1; next state BUSY with cnt=MUL_LAT-2.
  - BUSY with cnt!=0: same stall/flush set; cnt decrements.
  - BUSY with cnt==0 is the done cycle: MulDone=1, no stalls, FlushM=0; next state IDLE.
  - Total EX occupancy is exactly MUL_LAT cycles. Issue-to-done latency is MUL_LAT-1 cycles.
- Inside BUSY (including the done cycle): ldStall is masked, PCSrcE is ignored, and MulStartE is ignored. The held instruction keeps MulStartE high; re-issue is possible only from IDLE.
- MulStartE and ldStall together in IDLE: the multi-cycle stall set is applied, which is a superset, and FlushE=0. Load-use is re-evaluated after done.
- MulBusy=1 exactly when state==BUSY.

Optional Feature:
HAZARD_PERF_EN
- When defined, adds outputs StallCnt[CNT_W] (counts cycles with StallF=1) and FlushCnt[CNT_W] (counts cycles with PCSrcE-driven flush).
- Both counters saturate at all-ones and clear on reset.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - mul_state_t enum: IDLE, BUSY.
  - Constant PC_REG=4'hF.
- One sub-module, fwd_unit: a purely combinational forwarding compare, instantiated once per operand (A, B).

Test Plan:
- Forward priority: RegWriteM=RegWriteW=1, WA3M=WA3W=Ra1E=3 → ForwardAE=10. Same with RegWriteM=0 → 01. Ra1E=15 with a matching WA3M → 00.
- Load-use: MemtoRegE=1, WA3E=5, Ra2D=5 → StallF=StallD=FlushE=1 for exactly one cycle, then all 0.
- Branch beats load-use: MemtoRegE=1, WA3E=Ra1D=2, PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0.
- Multi-cycle, MUL_LAT=4: MulStartE held high from cycle 0 → stalls and FlushM=1 in cycles 0–2, MulBusy=1 in cycles 1–3, MulDone=1 only in cycle 3, IDLE in cycle 4.
- Reset mid-op: rst=0 sampled in cycle 1 of BUSY → next cycle IDLE, all outputs 0, no MulDone pulse. MUL_LAT=2 variant: MulDone in cycle 1.
- With HAZARD_PERF_EN: 3 branch flushes and one 4-cycle multi-cycle op → FlushCnt=3, StallCnt=3.
